benes_port_streamer: RTL and testbench

Module-side stream agent for one module port of the Benes buffer interconnect. It issues sequential slot reads through the interconnect and captures the returned 512-bit words after the fixed round-trip latency. It presents those words to the attached compute unit as a valid/ready stream and writes the unit's results back to a destination address as write requests. It is the initiator of the module-port protocol; the interconnect plus the buffer RAM slots form the responder.

---
 rtl/benes_port_streamer_pkg.sv | 42 ++++
 rtl/benes_port_fifo.sv | 69 ++++++
 rtl/benes_port_streamer.sv | 165 ++++++++++++++++
 tb/tb_benes_port_streamer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/benes_port_streamer_pkg.sv
// Shared types and constants for the Benes module-port stream agent.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package benes_port_streamer_pkg;

  // Interconnect geometry: a raddr crosses STAGE_NUM switch stages on the way
  // to the RAM and STAGE_NUM more on the way back, plus the RAM read itself.
  localparam int STAGE_NUM             = 8;
  localparam int BUFFER_READ_LATENCY   = 4;
  localparam int BENES_PORT_RD_LATENCY = 2*STAGE_NUM + BUFFER_READ_LATENCY;

  localparam int BENES_LEN_W = 16;
  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 512;

  // Module-port request into the interconnect (577 bits).
  typedef struct packed {
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] waddr;
    logic [WORD_W-1:0] wdata;
    logic              wren;
  } BufferRAMTEFsizeInputs;

  typedef struct packed {
    logic [ADDR_W-1:0]      src;
    logic [ADDR_W-1:0]      dst;
    logic [BENES_LEN_W-1:0] len;
  } BenesStreamCmd;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } stream_state_e;

  // Slot address of word idx of a transfer; wraps modulo 2^32.
  function automatic logic [ADDR_W-1:0] slot_addr(input logic [ADDR_W-1:0]      base,
                                                  input logic [BENES_LEN_W-1:0] idx);
    return base + ADDR_W'(idx);
  endfunction

endpackage

// File: rtl/benes_port_fifo.sv
// Show-ahead FIFO holding read words returned by the interconnect.
// Latency: a pushed word is visible at o_head the cycle after the push.
// Backpressure: push while full is dropped (callers must never do it); pop while empty is ignored.
// Ports: i_push/i_push_data write side, i_pop read side, o_head current head word,
//        o_count occupancy, o_full/o_empty flags.
module benes_port_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [AW:0]      o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = i_push & ~o_full;
    pop_ok   = i_pop & ~o_empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/benes_port_streamer.sv
// Module-port stream agent: sequential slot reads out, read words to the compute unit, results written back.
// Latency: raddr in issue cycle, data RD_LATENCY cycles later, o_m_valid the cycle after; writes 1 cycle after s handshake.
// Backpressure: reads are credit-limited by FIFO room (in-flight + stored < FIFO_DEPTH); o_s_ready drops once len results are taken.
// Ports: cmd (valid/ready, src/dst/len), o_ram_req/i_ram_rdata to the interconnect,
//        m-stream (read words out), s-stream (results in), o_busy/o_done status.
module benes_port_streamer
  import benes_port_streamer_pkg::*;
#(
  parameter int RD_LATENCY = BENES_PORT_RD_LATENCY,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_W      = BENES_LEN_W  // must equal the command struct's len width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_W-1:0]     i_cmd_src,
  input  logic [ADDR_W-1:0]     i_cmd_dst,
  input  logic [LEN_W-1:0]      i_cmd_len,
  output BufferRAMTEFsizeInputs o_ram_req,
  input  logic [WORD_W-1:0]     i_ram_rdata,
  output logic                  o_m_valid,
  output logic [WORD_W-1:0]     o_m_data,
  input  logic                  i_m_ready,
  input  logic                  i_s_valid,
  input  logic [WORD_W-1:0]     i_s_data,
  output logic                  o_s_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IF_W  = $clog2(RD_LATENCY + 1);

  stream_state_e         state_q, state_d;
  BenesStreamCmd         cmd_q, cmd_d;
  logic [LEN_W-1:0]      rd_issued_q, rd_issued_d;
  logic [LEN_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [RD_LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  wren_q, wren_d;

  logic [IF_W-1:0]       inflight;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        occupancy;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                  rd_issue, s_fire;

  // Reads that have left but not yet come back.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + IF_W'(vld_sr_q[i]);
    end
  end

  // Every in-flight read already owns a FIFO slot, so a push can never find the FIFO full.
  assign occupancy = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);
  assign fifo_push = vld_sr_q[RD_LATENCY-1];
  assign fifo_pop  = o_m_valid & i_m_ready;

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = (state_q == ST_DONE);
  assign o_s_ready   = (state_q == ST_RUN) && (wr_cnt_q < cmd_q.len);
  assign o_m_valid   = ~fifo_empty;

  // raddr is presented in the issue cycle itself so the shift register lines up with the return data.
  assign o_ram_req = '{raddr: raddr_d, waddr: waddr_q, wdata: wdata_q, wren: wren_q};

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rd_issued_d = rd_issued_q;
    wr_cnt_d    = wr_cnt_q;
    vld_sr_d    = {vld_sr_q[RD_LATENCY-2:0], 1'b0};
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    wren_d      = 1'b0;
    rd_issue    = 1'b0;
    s_fire      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          cmd_d       = '{src: i_cmd_src, dst: i_cmd_dst, len: i_cmd_len};
          rd_issued_d = '0;
          wr_cnt_d    = '0;
          vld_sr_d    = '0;
          state_d     = (i_cmd_len == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        rd_issue = (rd_issued_q < cmd_q.len) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
        if (rd_issue) begin
          raddr_d     = slot_addr(cmd_q.src, rd_issued_q);
          rd_issued_d = rd_issued_q + LEN_W'(1);
          vld_sr_d[0] = 1'b1;
        end

        s_fire = i_s_valid & o_s_ready;
        if (s_fire) begin
          wren_d   = 1'b1;
          waddr_d  = slot_addr(cmd_q.dst, wr_cnt_q);
          wdata_d  = i_s_data;
          wr_cnt_d = wr_cnt_q + LEN_W'(1);
        end

        // wr_cnt reaches len in the cycle the last write is on the port, so that write is never cut off.
        if ((wr_cnt_q == cmd_q.len) && (rd_issued_q == cmd_q.len) &&
            (inflight == '0) && fifo_empty) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      rd_issued_q <= '0;
      wr_cnt_q    <= '0;
      vld_sr_q    <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wren_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rd_issued_q <= rd_issued_d;
      wr_cnt_q    <= wr_cnt_d;
      vld_sr_q    <= vld_sr_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wren_q      <= wren_d;
    end
  end

  benes_port_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (fifo_push),
    .i_push_data (i_ram_rdata),
    .i_pop       (fifo_pop),
    .o_head      (o_m_data),
    .o_count     (fifo_count),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty)
  );

endmodule

// File: tb/tb_benes_port_streamer.sv
module tb_benes_port_streamer;
  import benes_port_streamer_pkg::*;

  localparam int RD_LAT = BENES_PORT_RD_LATENCY;

  logic                  clk;
  logic                  rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [31:0]           cmd_src;
  logic [31:0]           cmd_dst;
  logic [15:0]           cmd_len;
  BufferRAMTEFsizeInputs ram_req;
  logic [511:0]          ram_rdata = '0;
  logic                  m_valid;
  logic [511:0]          m_data;
  logic                  m_ready;
  logic                  s_valid = 1'b0;
  logic [511:0]          s_data = '0;
  logic                  s_ready;
  logic                  busy;
  logic                  done;

  int checks = 0;
  int passes = 0;

  benes_port_streamer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_src   (cmd_src),
    .i_cmd_dst   (cmd_dst),
    .i_cmd_len   (cmd_len),
    .o_ram_req   (ram_req),
    .i_ram_rdata (ram_rdata),
    .o_m_valid   (m_valid),
    .o_m_data    (m_data),
    .i_m_ready   (m_ready),
    .i_s_valid   (s_valid),
    .i_s_data    (s_data),
    .o_s_ready   (s_ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Content of RAM slot a, as returned by the responder model.
  function automatic logic [511:0] word_of(input logic [31:0] a);
    return {16{a ^ 32'h3C5A_9600}};
  endfunction

  // Environment: RAM responder, one-cycle loopback of the m-stream into the s-stream, monitors.
  logic [31:0]  rhist [RD_LAT+1];
  logic [31:0]  prev_raddr = '0;
  logic         lb_vld = 1'b0;
  logic [511:0] lb_dat = '0;
  int           cyc = 0;
  logic [31:0]  issue_q [$];
  int           issue_cyc [$];
  logic [511:0] m_q [$];
  logic [31:0]  wa_q [$];
  logic [511:0] wd_q [$];
  int           first_mv_cyc = -1;
  int           mv_cnt = 0;
  int           done_cnt = 0;
  int           ovf_cnt = 0;

  initial for (int k = 0; k <= RD_LAT; k++) rhist[k] = '0;

  always @(negedge clk) begin
    cyc++;
    for (int k = RD_LAT; k > 0; k--) rhist[k] = rhist[k-1];
    rhist[0]  = ram_req.raddr;
    ram_rdata = word_of(rhist[RD_LAT]);

    s_valid = lb_vld;
    s_data  = lb_dat;
    lb_vld  = m_valid & m_ready;
    lb_dat  = m_data;

    if (busy && (ram_req.raddr != prev_raddr)) begin
      issue_q.push_back(ram_req.raddr);
      issue_cyc.push_back(cyc);
    end
    prev_raddr = ram_req.raddr;
    if (m_valid) begin
      mv_cnt++;
      if (first_mv_cyc < 0) first_mv_cyc = cyc;
    end
    if (m_valid && m_ready) m_q.push_back(m_data);
    if (ram_req.wren) begin
      wa_q.push_back(ram_req.waddr);
      wd_q.push_back(ram_req.wdata);
    end
    if (done) done_cnt++;
    if (dut.fifo_push && dut.fifo_full) ovf_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    issue_q.delete();
    issue_cyc.delete();
    m_q.delete();
    wa_q.delete();
    wd_q.delete();
    first_mv_cyc = -1;
    mv_cnt   = 0;
    done_cnt = 0;
    ovf_cnt  = 0;
  endtask

  task automatic send_cmd(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    cmd_valid = 1'b1;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == 0) $display("FAIL %s_done_timeout got no o_done after %0d cycles, want o_done", name, budget);
    else passes++;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (ram_req !== '0) $display("FAIL reset_ram_req got %h want 0", ram_req); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid got %b want 0", m_valid); else passes++;
    checks++; if (m_data !== '0) $display("FAIL reset_m_data got nonzero want 0"); else passes++;
    checks++; if ({s_ready, busy, done} !== 3'b000) $display("FAIL reset_status got %b want 000", {s_ready, busy, done}); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); else passes++;
    rst_n = 1'b1;
    tick();
    checks++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL reset_release got %b want 10", {cmd_ready, busy}); else passes++;
  endtask

  task automatic test_copy();
    m_ready = 1'b1;
    clear_mon();
    send_cmd(32'h100, 32'h200, 16'd4);
    wait_done(200, "copy");
    checks++; if (issue_q.size() !== 4) $display("FAIL copy_issue_count got %0d want 4", issue_q.size()); else passes++;
    for (int i = 0; i < issue_q.size(); i++) begin
      checks++;
      if (issue_q[i] !== 32'h100 + 32'(i) || issue_cyc[i] !== issue_cyc[0] + i)
        $display("FAIL copy_raddr[%0d] got %h at +%0d want %h at +%0d", i, issue_q[i], issue_cyc[i] - issue_cyc[0], 32'h100 + 32'(i), i);
      else passes++;
    end
    // o_m_valid rises RD_LAT clock edges after the edge that commits the first issue.
    checks++;
    if (issue_cyc.size() == 0 || first_mv_cyc - (issue_cyc[0] + 1) !== RD_LAT)
      $display("FAIL copy_first_valid_latency got %0d want %0d", issue_cyc.size() == 0 ? -1 : first_mv_cyc - (issue_cyc[0] + 1), RD_LAT);
    else passes++;
    checks++; if (wa_q.size() !== 4) $display("FAIL copy_write_count got %0d want 4", wa_q.size()); else passes++;
    for (int i = 0; i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h200 + 32'(i) || wd_q[i] !== word_of(32'h100 + 32'(i)))
        $display("FAIL copy_write[%0d] got addr %h data %h want addr %h data %h", i, wa_q[i], wd_q[i][31:0], 32'h200 + 32'(i), word_of(32'h100 + 32'(i)) & 512'hFFFF_FFFF);
      else passes++;
    end
    repeat (10) tick();
    checks++; if (done_cnt !== 1) $display("FAIL copy_done_count got %0d want 1", done_cnt); else passes++;
  endtask

  task automatic test_len_zero();
    clear_mon();
    cmd_valid = 1'b1; cmd_src = 32'h500; cmd_dst = 32'h600; cmd_len = 16'd0;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL len0_cmd_ready got %b want 1", cmd_ready); else passes++;
    tick();
    cmd_valid = 1'b0;
    checks++; if ({done, cmd_ready, s_ready} !== 3'b100) $display("FAIL len0_done_cycle got %b want 100", {done, cmd_ready, s_ready}); else passes++;
    tick();
    checks++; if ({done, cmd_ready} !== 2'b01) $display("FAIL len0_after got %b want 01", {done, cmd_ready}); else passes++;
    repeat (30) tick();
    checks++;
    if (wa_q.size() !== 0 || mv_cnt !== 0 || done_cnt !== 1)
      $display("FAIL len0_quiet got wren %0d m_valid %0d done %0d want 0 0 1", wa_q.size(), mv_cnt, done_cnt);
    else passes++;
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    clear_mon();
    send_cmd(32'h1000, 32'h2000, 16'd64);
    repeat (59) tick();
    checks++; if (issue_q.size() !== 32) $display("FAIL bp_issue_stall got %0d want 32", issue_q.size()); else passes++;
    checks++; if (ram_req.raddr !== 32'h101F) $display("FAIL bp_raddr_hold got %h want 0000101f", ram_req.raddr); else passes++;
    checks++; if (m_valid !== 1'b1) $display("FAIL bp_m_valid got %b want 1", m_valid); else passes++;
    m_ready = 1'b1;
    wait_done(600, "bp");
    checks++; if (issue_q.size() !== 64) $display("FAIL bp_issue_total got %0d want 64", issue_q.size()); else passes++;
    checks++; if (ovf_cnt !== 0) $display("FAIL bp_overflow got %0d want 0", ovf_cnt); else passes++;
    checks++; if (m_q.size() !== 64) $display("FAIL bp_m_count got %0d want 64", m_q.size()); else passes++;
    for (int i = 0; i < m_q.size(); i++) begin
      checks++;
      if (m_q[i] !== word_of(32'h1000 + 32'(i))) $display("FAIL bp_m_data[%0d] got %h want %h", i, m_q[i][31:0], 32'h1000 + 32'(i) ^ 32'h3C5A_9600);
      else passes++;
    end
    checks++; if (wa_q.size() !== 64) $display("FAIL bp_write_count got %0d want 64", wa_q.size()); else passes++;
    for (int i = 0; i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h2000 + 32'(i) || wd_q[i] !== word_of(32'h1000 + 32'(i)))
        $display("FAIL bp_write[%0d] got addr %h data %h want addr %h", i, wa_q[i], wd_q[i][31:0], 32'h2000 + 32'(i));
      else passes++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0001;
    m_ready = 1'b1;
    clear_mon();
    send_cmd(32'hFFFF_FFFE, 32'h40, 16'd4);
    wait_done(200, "wrap");
    checks++; if (issue_q.size() !== 4) $display("FAIL wrap_issue_count got %0d want 4", issue_q.size()); else passes++;
    for (int i = 0; i < issue_q.size() && i < 4; i++) begin
      checks++;
      if (issue_q[i] !== exp_a[i]) $display("FAIL wrap_raddr[%0d] got %h want %h", i, issue_q[i], exp_a[i]);
      else passes++;
    end
    checks++; if (wd_q.size() !== 4) $display("FAIL wrap_write_count got %0d want 4", wd_q.size()); else passes++;
    for (int i = 0; i < wd_q.size() && i < 4; i++) begin
      checks++;
      if (wd_q[i] !== word_of(exp_a[i]) || wa_q[i] !== 32'h40 + 32'(i))
        $display("FAIL wrap_write[%0d] got addr %h data %h want addr %h", i, wa_q[i], wd_q[i][31:0], 32'h40 + 32'(i));
      else passes++;
    end
  endtask

  task automatic test_busy_cmd();
    m_ready = 1'b1;
    clear_mon();
    send_cmd(32'h300, 32'h400, 16'd8);
    repeat (5) tick();
    cmd_valid = 1'b1; cmd_src = 32'h900; cmd_dst = 32'hA00; cmd_len = 16'd3;
    checks++; if ({cmd_ready, busy} !== 2'b01) $display("FAIL busy_cmd_ready got %b want 01", {cmd_ready, busy}); else passes++;
    tick();
    cmd_valid = 1'b0; cmd_src = '0; cmd_dst = '0; cmd_len = '0;
    wait_done(200, "busy");
    repeat (60) tick();
    checks++; if (issue_q.size() !== 8) $display("FAIL busy_issue_count got %0d want 8", issue_q.size()); else passes++;
    for (int i = 0; i < issue_q.size(); i++) begin
      checks++;
      if (issue_q[i] !== 32'h300 + 32'(i)) $display("FAIL busy_raddr[%0d] got %h want %h", i, issue_q[i], 32'h300 + 32'(i));
      else passes++;
    end
    checks++; if (wa_q.size() !== 8) $display("FAIL busy_write_count got %0d want 8", wa_q.size()); else passes++;
    for (int i = 0; i < wa_q.size(); i++) begin
      checks++;
      if (wa_q[i] !== 32'h400 + 32'(i) || wd_q[i] !== word_of(32'h300 + 32'(i)))
        $display("FAIL busy_write[%0d] got addr %h want %h", i, wa_q[i], 32'h400 + 32'(i));
      else passes++;
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) $display("FAIL busy_second_cmd got done %0d busy %b want 1 0", done_cnt, busy);
    else passes++;
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    m_ready = 1'b1;
    clear_mon();
    send_cmd(32'h7000, 32'h8000, 16'd32);
    while (issue_q.size() < 10 && n < 100) begin
      tick();
      n++;
    end
    checks++; if (issue_q.size() < 10) $display("FAIL rst_issue_timeout got %0d issues want 10", issue_q.size()); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (ram_req !== '0) $display("FAIL rst_ram_req got %h want 0", ram_req); else passes++;
    checks++;
    if ({m_valid, s_ready, busy, done} !== 4'b0000 || m_data !== '0)
      $display("FAIL rst_outputs got %b want 0000", {m_valid, s_ready, busy, done});
    else passes++;
    repeat (3) tick();
    rst_n = 1'b1;
    clear_mon();
    tick();
    checks++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL rst_release got %b want 10", {cmd_ready, busy}); else passes++;
    repeat (40) tick();
    checks++;
    if (done_cnt !== 0 || issue_q.size() !== 0 || wa_q.size() !== 0)
      $display("FAIL rst_aborted got done %0d issues %0d writes %0d want 0 0 0", done_cnt, issue_q.size(), wa_q.size());
    else passes++;
    send_cmd(32'h7100, 32'h8100, 16'd2);
    wait_done(200, "rst_fresh");
    checks++;
    if (issue_q.size() !== 2 || wa_q.size() !== 2)
      $display("FAIL rst_fresh_counts got issues %0d writes %0d want 2 2", issue_q.size(), wa_q.size());
    else passes++;
    for (int i = 0; i < wa_q.size() && i < issue_q.size(); i++) begin
      checks++;
      if (issue_q[i] !== 32'h7100 + 32'(i) || wa_q[i] !== 32'h8100 + 32'(i) || wd_q[i] !== word_of(32'h7100 + 32'(i)))
        $display("FAIL rst_fresh[%0d] got raddr %h waddr %h want %h %h", i, issue_q[i], wa_q[i], 32'h7100 + 32'(i), 32'h8100 + 32'(i));
      else passes++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL rst_fresh_done got %0d want 1", done_cnt); else passes++;
  endtask

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    m_ready   = 1'b0;
    test_reset();
    test_copy();
    test_len_zero();
    test_backpressure();
    test_wrap();
    test_busy_cmd();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
